blink_rate_ctrl: RTL and testbench

Upstream control stage for the LED blink toggler. It debounces a raw on-board push button and steps through four blink-rate modes on each press. It emits a one-cycle toggle strobe at the selected half-period; the downstream toggler flips the LED pin on every strobe. It replaces the toggler's fixed free-running 0.5 s counter with a user-selectable rate.

---
 rtl/blink_rate_ctrl_if.sv | 22 ++
 rtl/blink_rate_ctrl.sv | 118 +++++++++++
 tb/tb_blink_rate_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/blink_rate_ctrl_if.sv
// Button-side and LED-side signals of the blink-rate controller.
// Master drives the raw button pin; slave (the controller) drives the rate outputs.
interface blink_rate_ctrl_if;
  logic       Button;
  logic       Toggle_strobe;
  logic [1:0] Mode;
  logic       Press_pulse;

  modport master (
    output Button,
    input  Toggle_strobe,
    input  Mode,
    input  Press_pulse
  );

  modport slave (
    input  Button,
    output Toggle_strobe,
    output Mode,
    output Press_pulse
  );
endinterface

// File: rtl/blink_rate_ctrl.sv
// Debounced push button stepping through four blink rates.
// Emits a one-cycle toggle strobe every selected half-period.
module blink_rate_ctrl #(
  parameter int unsigned CLK_HZ            = 27_000_000,
  parameter int unsigned DEBOUNCE_CYCLES   = 270_000,
  parameter int unsigned BASE_HALF_PERIOD  = 13_500_000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  blink_rate_ctrl_if.slave  bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PC_W = $clog2(BASE_HALF_PERIOD);

  localparam logic RELEASED_LVL = BUTTON_ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam logic [1:0] MODE_BASE    = 2'd0;
  localparam logic [1:0] MODE_HALF    = 2'd1;
  localparam logic [1:0] MODE_QUARTER = 2'd2;
  localparam logic [1:0] MODE_HOLD    = 2'd3;

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_deb;
  logic            r_deb_d;
  logic            r_press;
  logic [1:0]      r_mode;
  logic [PC_W-1:0] r_per_cnt;
  logic            r_strobe;

  logic            w_pressed;
  logic            w_rise;
  logic [PC_W-1:0] w_half_m1;
  logic            w_unused_clk_hz;

  assign w_unused_clk_hz = (CLK_HZ != 0);

  // Synchronised level normalised so that 1 always means pressed.
  assign w_pressed = r_sync2 ^ RELEASED_LVL;
  assign w_rise    = r_deb & ~r_deb_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= RELEASED_LVL;
      r_sync2 <= RELEASED_LVL;
    end else begin
      r_sync1 <= bus.Button;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_db_cnt <= '0;
      r_deb    <= 1'b0;
      r_deb_d  <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      if (w_pressed != r_deb) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_deb    <= w_pressed;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_press <= 1'b0;
      r_mode  <= MODE_BASE;
    end else begin
      r_press <= w_rise;
      if (w_rise) begin
        r_mode <= r_mode + 2'd1;
      end
    end
  end

  always_comb begin
    w_half_m1 = '0;
    case (r_mode)
      MODE_BASE:    w_half_m1 = PC_W'(BASE_HALF_PERIOD - 1);
      MODE_HALF:    w_half_m1 = PC_W'((BASE_HALF_PERIOD >> 1) - 1);
      MODE_QUARTER: w_half_m1 = PC_W'((BASE_HALF_PERIOD >> 2) - 1);
      default:      w_half_m1 = '0;
    endcase
  end

  // A mode change restarts the period and drops any coincident terminal count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_per_cnt <= '0;
      r_strobe  <= 1'b0;
    end else if (w_rise || (r_mode == MODE_HOLD)) begin
      r_per_cnt <= '0;
      r_strobe  <= 1'b0;
    end else if (r_per_cnt == w_half_m1) begin
      r_per_cnt <= '0;
      r_strobe  <= 1'b1;
    end else begin
      r_per_cnt <= r_per_cnt + PC_W'(1);
      r_strobe  <= 1'b0;
    end
  end

  assign bus.Toggle_strobe = r_strobe;
  assign bus.Mode          = r_mode;
  assign bus.Press_pulse   = r_press;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl: table of button patterns plus hand sequences,
// with expected press events queued at drive time and strobes predicted from the phase.
module tb_blink_rate_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BASE = 16;
  localparam int          PRESS_LAT = 2 + DEB + 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  bit   clk_en = 1'b0;

  blink_rate_ctrl_if bus ();

  blink_rate_ctrl #(
    .CLK_HZ            (27_000_000),
    .DEBOUNCE_CYCLES   (DEB),
    .BASE_HALF_PERIOD  (BASE),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) Clock = ~Clock;
  end

  typedef struct {
    int cyc;
    int mode;
  } ev_t;

  typedef struct {
    int low;
    int high;
    int reps;
    bit press;
    int mode;
  } vec_t;

  ev_t  q[$];
  vec_t vec[6];

  int cyc       = 0;
  int phase_ref = 0;
  int exp_mode  = 0;
  int sched_mode = 0;
  int n_err     = 0;
  int n_chk     = 0;

  function automatic int half_of(input int m);
    return int'(BASE) >> m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock; compare outputs on the falling edge against the model.
  task automatic tick();
    int exp_pulse;
    int exp_strobe;
    @(negedge Clock);
    cyc++;
    if (!Reset) begin
      exp_pulse = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_pulse = 1;
        exp_mode  = q[0].mode;
        phase_ref = cyc;
        void'(q.pop_front());
      end
      exp_strobe = (exp_mode != 3 && cyc != phase_ref &&
                    ((cyc - phase_ref) % half_of(exp_mode)) == 0) ? 1 : 0;
      check("press_pulse",   int'(bus.Press_pulse),   exp_pulse);
      check("mode",          int'(bus.Mode),          exp_mode);
      check("toggle_strobe", int'(bus.Toggle_strobe), exp_strobe);
    end
  endtask

  task automatic expect_press();
    sched_mode = (sched_mode + 1) % 4;
    q.push_back('{cyc + PRESS_LAT, sched_mode});
  endtask

  task automatic press_run(input int low, input int high);
    bus.Button = 1'b0;
    repeat (low) tick();
    bus.Button = 1'b1;
    repeat (high) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{3,   1, 5, 1'b0, 0};
    vec[1] = '{3,  12, 1, 1'b0, 0};
    vec[2] = '{20, 20, 1, 1'b1, 1};
    vec[3] = '{4,  12, 1, 1'b1, 2};
    vec[4] = '{6, 100, 1, 1'b1, 3};
    vec[5] = '{20, 40, 1, 1'b1, 0};

    bus.Button = 1'b1;
    Reset = 1'b1;
    #3;
    check("reset_strobe", int'(bus.Toggle_strobe), 0);
    check("reset_pulse",  int'(bus.Press_pulse),   0);
    check("reset_mode",   int'(bus.Mode),          0);

    clk_en = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    phase_ref = cyc;

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < vec[i].reps; r++) begin
        if (vec[i].press && r == 0) expect_press();
        press_run(vec[i].low, vec[i].high);
      end
      repeat (12) tick();
      check($sformatf("mode_after_vec%0d", i), int'(bus.Mode), vec[i].mode);
    end

    // Land the mode update exactly on a terminal-count edge in mode 0.
    for (int k = 0; k < 32 && ((cyc + PRESS_LAT - phase_ref) % half_of(0)) != 0; k++)
      tick();
    expect_press();
    press_run(20, 20);
    repeat (12) tick();
    check("mode_after_coincident", int'(bus.Mode), 1);

    // Reset after three of the four debounce counts, button still held.
    bus.Button = 1'b0;
    repeat (DEB + 1) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("midreset_strobe", int'(bus.Toggle_strobe), 0);
    check("midreset_pulse",  int'(bus.Press_pulse),   0);
    check("midreset_mode",   int'(bus.Mode),          0);
    tick();
    Reset = 1'b0;
    q.delete();
    exp_mode   = 0;
    sched_mode = 0;
    phase_ref  = cyc;
    expect_press();
    repeat (20) tick();
    bus.Button = 1'b1;
    repeat (20) tick();
    check("mode_after_midreset", int'(bus.Mode), 1);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
